// File: rtl/mem_stage.sv
// Memory-access stage: drives the synchronous data RAM, checks alignment,
// extends load data and owns the MEM->WB pipeline register.
module mem_stage #(
   parameter int DM_LAT = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         MEM_valid,
   input  logic [155:0] EXE_MEM_bus_r,
   input  logic         WB_allow_in,
   input  logic         cancel,
   input  logic [31:0]  dm_rdata,
   output logic         dm_en,
   output logic [3:0]   dm_wen,
   output logic [31:0]  dm_addr,
   output logic [31:0]  dm_wdata,
   output logic         MEM_over,
   output logic         MEM_allow_in,
   output logic [4:0]   MEM_wdest,
   output logic         WB_valid,
   output logic [153:0] MEM_WB_bus_r
);

   generate
      if (DM_LAT != 1) begin : g_lat_unsupported
         $fatal(1, "mem_stage supports only DM_LAT == 1");
      end
   endgenerate

   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LB  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;

   typedef enum logic [1:0] {IDLE = 2'd0, LWAIT = 2'd1, HOLD = 2'd2} state_t;

   function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      half_v = a[1] ? w[31:16] : w[15:0];
      case (a)
         2'd0:    byte_v = w[7:0];
         2'd1:    byte_v = w[15:8];
         2'd2:    byte_v = w[23:16];
         default: byte_v = w[31:24];
      endcase
      case (op)
         OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_ext = {16'h0000, half_v};
         OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_ext = {24'h000000, byte_v};
         default: load_ext = w;
      endcase
   endfunction

   function automatic logic [3:0] store_wen(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_SW:   store_wen = 4'b1111;
         OP_SH:   store_wen = 4'b0011 << a;
         OP_SB:   store_wen = 4'b0001 << a;
         default: store_wen = 4'b0000;
      endcase
   endfunction

   state_t        state_r, state_nxt_s;
   logic [31:0]   held_r;
   logic [3:0]    mem_op_s;
   logic [31:0]   store_data_s, exe_result_s, load_res_s, mem_result_s;
   logic [1:0]    a_s;
   logic          is_load_s, is_store_s, adel_s, ades_s;
   logic          load_ok_s, store_ok_s, over_s, wb_wen_s;
   logic [153:0]  wb_bus_s;

   assign mem_op_s     = EXE_MEM_bus_r[155:152];
   assign store_data_s = EXE_MEM_bus_r[151:120];
   assign exe_result_s = EXE_MEM_bus_r[119:88];
   assign a_s          = exe_result_s[1:0];

   // Decode the access type and the alignment exceptions
   always_comb begin
      is_load_s  = 1'b0;
      is_store_s = 1'b0;
      adel_s     = 1'b0;
      ades_s     = 1'b0;
      case (mem_op_s)
         OP_LW:          begin is_load_s  = 1'b1; adel_s = (a_s != 2'd0); end
         OP_LH, OP_LHU:  begin is_load_s  = 1'b1; adel_s = a_s[0];        end
         OP_LB, OP_LBU:  begin is_load_s  = 1'b1;                         end
         OP_SW:          begin is_store_s = 1'b1; ades_s = (a_s != 2'd0); end
         OP_SH:          begin is_store_s = 1'b1; ades_s = a_s[0];        end
         OP_SB:          begin is_store_s = 1'b1;                         end
         default:        begin is_load_s  = 1'b0;                         end
      endcase
   end

   assign load_ok_s  = is_load_s & ~adel_s;
   assign store_ok_s = is_store_s & ~ades_s;

   // Next-state and completion logic
   always_comb begin
      state_nxt_s = state_r;
      over_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (MEM_valid & load_ok_s) begin
               state_nxt_s = LWAIT;
            end else begin
               over_s = MEM_valid;
            end
         end
         LWAIT: begin
            over_s = MEM_valid;
            if (WB_allow_in) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         HOLD: begin
            over_s = MEM_valid;
            if (WB_allow_in) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      if (cancel) begin
         state_nxt_s = IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // RAM strobes are forced low while in reset or being flushed
   assign dm_en    = resetn & ~cancel & MEM_valid & (state_r == IDLE)
                     & (load_ok_s | (store_ok_s & WB_allow_in));
   assign dm_wen   = (dm_en & store_ok_s) ? store_wen(mem_op_s, a_s) : 4'b0000;
   assign dm_addr  = {exe_result_s[31:2], 2'b00};
   assign dm_wdata = (mem_op_s == OP_SB) ? {4{store_data_s[7:0]}}
                   : (mem_op_s == OP_SH) ? {2{store_data_s[15:0]}} : store_data_s;

   assign MEM_over     = over_s & resetn;
   assign MEM_allow_in = ~MEM_valid | (MEM_over & WB_allow_in);
   assign MEM_wdest    = EXE_MEM_bus_r[36:32] & {5{MEM_valid}};

   assign load_res_s   = load_ext(mem_op_s, a_s, (state_r == HOLD) ? held_r : dm_rdata);
   assign mem_result_s = load_ok_s ? load_res_s : exe_result_s;
   assign wb_wen_s     = EXE_MEM_bus_r[37] & ~adel_s & ~ades_s;
   assign wb_bus_s     = {wb_wen_s, EXE_MEM_bus_r[36:32], mem_result_s, EXE_MEM_bus_r[87:56],
                          EXE_MEM_bus_r[55:40], EXE_MEM_bus_r[31:0], exe_result_s,
                          EXE_MEM_bus_r[39:38], adel_s, ades_s};

   // State register and stalled-load data capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         held_r  <= 32'h0000_0000;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == LWAIT) & ~WB_allow_in & ~cancel) begin
            held_r <= dm_rdata;
         end else begin
            held_r <= held_r;
         end
      end
   end

   // MEM->WB pipeline register; a flush beats a simultaneous transfer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         WB_valid     <= 1'b0;
         MEM_WB_bus_r <= 154'd0;
      end else if (cancel) begin
         WB_valid     <= 1'b0;
      end else if (MEM_over & WB_allow_in) begin
         WB_valid     <= 1'b1;
         MEM_WB_bus_r <= wb_bus_s;
      end else if (WB_allow_in) begin
         WB_valid     <= 1'b0;
      end else begin
         WB_valid     <= WB_valid;
      end
   end

   mem_stage_chk u_chk (
      .clk          (clk),
      .resetn       (resetn),
      .MEM_valid    (MEM_valid),
      .MEM_over     (MEM_over),
      .WB_allow_in  (WB_allow_in),
      .cancel       (cancel),
      .EXE_MEM_bus_r(EXE_MEM_bus_r)
   );

endmodule

// Protocol checker: the EXE->MEM bus must hold still until the stage hands off.
module mem_stage_chk (
   input logic         clk,
   input logic         resetn,
   input logic         MEM_valid,
   input logic         MEM_over,
   input logic         WB_allow_in,
   input logic         cancel,
   input logic [155:0] EXE_MEM_bus_r
);
   property p_bus_stable;
      @(posedge clk) disable iff (!resetn)
         (MEM_valid && !(MEM_over && WB_allow_in) && !cancel) |=> $stable(EXE_MEM_bus_r);
   endproperty
   a_bus_stable: assert property (p_bus_stable);
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a behavioural RAM, a reference model that
// predicts each WB bus word, and directed hazard/flush/reset scenarios.
module tb_mem_stage;
   logic         clk = 1'b0;
   logic         resetn, MEM_valid, WB_allow_in, cancel;
   logic [155:0] EXE_MEM_bus_r;
   logic [31:0]  dm_rdata, dm_addr, dm_wdata;
   logic         dm_en, MEM_over, MEM_allow_in, WB_valid;
   logic [3:0]   dm_wen;
   logic [4:0]   MEM_wdest;
   logic [153:0] MEM_WB_bus_r;

   int n_checks = 0;
   int n_errors = 0;
   logic [153:0] sb_q[$];

   logic [31:0] ram [0:255];
   logic [31:0] rd_r, junk_r;
   logic        scramble, poke_en, pend;
   logic [7:0]  poke_idx;
   logic [31:0] poke_data;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .resetn(resetn), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(EXE_MEM_bus_r),
      .WB_allow_in(WB_allow_in), .cancel(cancel), .dm_rdata(dm_rdata), .dm_en(dm_en),
      .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .MEM_over(MEM_over),
      .MEM_allow_in(MEM_allow_in), .MEM_wdest(MEM_wdest), .WB_valid(WB_valid),
      .MEM_WB_bus_r(MEM_WB_bus_r)
   );

   // behavioural synchronous RAM with 1-cycle read latency plus bench preload port
   always @(posedge clk) begin
      junk_r <= $urandom;
      if (poke_en) ram[poke_idx] <= poke_data;
      if (dm_en) begin
         for (int b = 0; b < 4; b++)
            if (dm_wen[b]) ram[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
         rd_r <= ram[dm_addr[9:2]];
      end
   end
   assign dm_rdata = scramble ? junk_r : rd_r;

   task automatic check(input string tag, input logic [153:0] got, input logic [153:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // a transfer seen at one negedge must show up on the WB register by the next one
   always @(negedge clk) begin
      if (pend) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", 154'd1, 154'd0);
         end else begin
            check("wb_valid", {153'd0, WB_valid}, 154'd1);
            check("wb_bus", MEM_WB_bus_r, sb_q.pop_front());
         end
      end
      pend = MEM_over && WB_allow_in && !cancel && resetn;
   end

   function automatic logic [155:0] mk_exe(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] sd, input logic wen,
                                           input logic [4:0] wd, input logic [31:0] pc);
      return {op, sd, addr, pc ^ 32'h5A5A_5A5A, 6'b100101, 8'h3C, 2'b01, 2'b10, wen, wd, pc};
   endfunction

   function automatic logic adel_m(input logic [3:0] op, input logic [31:0] addr);
      return (op == 4'd1 && addr[1:0] != 2'd0) || ((op == 4'd2 || op == 4'd3) && addr[0]);
   endfunction

   function automatic logic ades_m(input logic [3:0] op, input logic [31:0] addr);
      return (op == 4'd6 && addr[1:0] != 2'd0) || (op == 4'd7 && addr[0]);
   endfunction

   function automatic logic [153:0] mk_wb(input logic [3:0] op, input logic [31:0] addr,
                                          input logic wen, input logic [4:0] wd,
                                          input logic [31:0] pc, input logic [31:0] word);
      logic [31:0] sh, res;
      logic        ae, se;
      ae = adel_m(op, addr);
      se = ades_m(op, addr);
      sh = word >> (8 * addr[1:0]);
      case (op)
         4'd1:    res = word;
         4'd2:    res = {{16{sh[15]}}, sh[15:0]};
         4'd3:    res = {16'h0000, sh[15:0]};
         4'd4:    res = {{24{sh[7]}}, sh[7:0]};
         4'd5:    res = {24'h000000, sh[7:0]};
         default: res = addr;
      endcase
      if (ae) res = addr;
      return {wen & ~ae & ~se, wd, res, pc ^ 32'h5A5A_5A5A, 6'b100101, 8'h3C, 2'b01,
              pc, addr, 2'b10, ae, se};
   endfunction

   task automatic poke(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      poke_idx = addr[9:2]; poke_data = data; poke_en = 1'b1;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic wait_xfer(output int lat);
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (n > 0) @(negedge clk);
         if (MEM_over && WB_allow_in) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) check("xfer_timeout", 154'd0, 154'd1);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic wen, input logic [4:0] wd,
                         input logic [31:0] pc);
      logic       ld, st;
      logic [3:0] ewen;
      logic [31:0] ewd;
      int lat;
      ld = (op >= 4'd1 && op <= 4'd5) && !adel_m(op, addr);
      st = (op >= 4'd6 && op <= 4'd8) && !ades_m(op, addr);
      ewen = !st ? 4'b0000 : (op == 4'd6) ? 4'b1111 :
             (op == 4'd7) ? (4'b0011 << addr[1:0]) : (4'b0001 << addr[1:0]);
      ewd = (op == 4'd7) ? {2{sd[15:0]}} : (op == 4'd8) ? {4{sd[7:0]}} : sd;
      sb_q.push_back(mk_wb(op, addr, wen, wd, pc, ram[addr[9:2]]));
      @(posedge clk); #1;
      EXE_MEM_bus_r = mk_exe(op, addr, sd, wen, wd, pc);
      MEM_valid = 1'b1;
      @(negedge clk);
      check({tag, "_dm_en"}, {153'd0, dm_en}, {153'd0, ld | st});
      check({tag, "_dm_wen"}, {150'd0, dm_wen}, {150'd0, ewen});
      check({tag, "_dm_addr"}, {122'd0, dm_addr}, {122'd0, addr[31:2], 2'b00});
      check({tag, "_wdest"}, {149'd0, MEM_wdest}, {149'd0, wd});
      if (st) check({tag, "_wdata"}, {122'd0, dm_wdata}, {122'd0, ewd});
      wait_xfer(lat);
      check({tag, "_latency"}, lat, ld ? 154'd1 : 154'd0);
      @(posedge clk); #1;
      MEM_valid = 1'b0;
   endtask

   initial begin
      int lat;
      resetn = 1'b0; cancel = 1'b0; WB_allow_in = 1'b1; scramble = 1'b0; poke_en = 1'b0;
      pend = 1'b0; poke_idx = 8'd0; poke_data = 32'd0; rd_r = 32'd0;
      EXE_MEM_bus_r = mk_exe(4'd1, 32'h100, 32'd0, 1'b1, 5'd1, 32'h0);
      MEM_valid = 1'b1;
      @(negedge clk);
      check("rst_dm_en", {153'd0, dm_en}, 154'd0);
      check("rst_over", {153'd0, MEM_over}, 154'd0);
      check("rst_wb_valid", {153'd0, WB_valid}, 154'd0);
      check("rst_bus", MEM_WB_bus_r, 154'd0);
      MEM_valid = 1'b0;
      poke(32'h100, 32'hDEAD_BEEF);
      poke(32'h200, 32'h1111_2222);
      poke(32'h104, 32'h00C3_0000);
      @(posedge clk); #1 resetn = 1'b1;

      run_op("lw",  4'd1, 32'h100, 32'd0, 1'b1, 5'd3, 32'hBFC0_0000);
      poke(32'h100, 32'h80FF_0011);
      run_op("lb",  4'd4, 32'h103, 32'd0, 1'b1, 5'd4, 32'hBFC0_0004);
      run_op("lbu", 4'd5, 32'h103, 32'd0, 1'b1, 5'd5, 32'hBFC0_0008);
      run_op("lh",  4'd2, 32'h102, 32'd0, 1'b1, 5'd6, 32'hBFC0_000C);
      run_op("lhu", 4'd3, 32'h102, 32'd0, 1'b1, 5'd7, 32'hBFC0_0010);
      run_op("sh",  4'd7, 32'h202, 32'h1234_ABCD, 1'b0, 5'd0, 32'hBFC0_0014);
      check("sh_ram", {122'd0, ram[8'h80]}, {122'd0, 32'hABCD_2222});
      run_op("sb",  4'd8, 32'h201, 32'h0000_0077, 1'b0, 5'd0, 32'hBFC0_0018);
      run_op("lw2", 4'd1, 32'h200, 32'd0, 1'b1, 5'd8, 32'hBFC0_001C);
      run_op("adel_lw",  4'd1, 32'h101, 32'd0, 1'b1, 5'd9, 32'hBFC0_0020);
      run_op("adel_lhu", 4'd3, 32'h103, 32'd0, 1'b1, 5'd10, 32'hBFC0_0024);
      run_op("ades_sw",  4'd6, 32'h102, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hBFC0_0028);
      run_op("ades_sh",  4'd7, 32'h203, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hBFC0_002C);
      run_op("sw",  4'd6, 32'h204, 32'hCAFE_F00D, 1'b0, 5'd0, 32'hBFC0_0030);
      run_op("nop9", 4'd9, 32'h333, 32'd0, 1'b1, 5'd11, 32'hBFC0_0034);
      check("sw_ram", {122'd0, ram[8'h81]}, {122'd0, 32'hCAFE_F00D});
      check("sb_ram", {122'd0, ram[8'h80]}, {122'd0, 32'hABCD_7722});

      // stalled load: first-cycle data must survive a changing dm_rdata
      poke(32'h100, 32'hDEAD_BEEF);
      sb_q.push_back(mk_wb(4'd1, 32'h100, 1'b1, 5'd12, 32'hBFC0_0038, 32'hDEAD_BEEF));
      @(posedge clk); #1;
      EXE_MEM_bus_r = mk_exe(4'd1, 32'h100, 32'd0, 1'b1, 5'd12, 32'hBFC0_0038);
      MEM_valid = 1'b1; WB_allow_in = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_over_lwait", {153'd0, MEM_over}, 154'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 scramble = 1'b1;
         @(negedge clk);
         check("hold_over", {153'd0, MEM_over}, 154'd1);
      end
      @(posedge clk); #1 WB_allow_in = 1'b1;
      wait_xfer(lat);
      @(posedge clk); #1 MEM_valid = 1'b0;
      @(negedge clk);
      scramble = 1'b0;

      // flush while waiting for load data
      @(posedge clk); #1;
      EXE_MEM_bus_r = mk_exe(4'd1, 32'h100, 32'd0, 1'b1, 5'd13, 32'hBFC0_003C);
      MEM_valid = 1'b1;
      @(posedge clk); #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      @(negedge clk);
      check("cancel_wb_valid", {153'd0, WB_valid}, 154'd0);
      check("cancel_idle_over", {153'd0, MEM_over}, 154'd0);
      check("cancel_reissue", {153'd0, dm_en}, 154'd1);
      sb_q.push_back(mk_wb(4'd1, 32'h100, 1'b1, 5'd13, 32'hBFC0_003C, 32'hDEAD_BEEF));
      wait_xfer(lat);
      check("reissue_latency", lat, 154'd1);
      @(posedge clk); #1 MEM_valid = 1'b0;

      // flush with a store pending
      @(posedge clk); #1;
      EXE_MEM_bus_r = mk_exe(4'd6, 32'h100, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'hBFC0_0040);
      MEM_valid = 1'b1; cancel = 1'b1;
      @(negedge clk);
      check("cancel_sw_wen", {150'd0, dm_wen}, 154'd0);
      check("cancel_sw_en", {153'd0, dm_en}, 154'd0);
      @(posedge clk); #1 cancel = 1'b0; MEM_valid = 1'b0;
      @(negedge clk);
      check("cancel_sw_ram", {122'd0, ram[8'h40]}, {122'd0, 32'hDEAD_BEEF});

      // reset in the middle of a load
      @(posedge clk); #1;
      EXE_MEM_bus_r = mk_exe(4'd1, 32'h104, 32'd0, 1'b1, 5'd14, 32'hBFC0_0044);
      MEM_valid = 1'b1;
      @(posedge clk); #1 resetn = 1'b0;
      #1;
      check("rst_mid_valid", {153'd0, WB_valid}, 154'd0);
      check("rst_mid_bus", MEM_WB_bus_r, 154'd0);
      check("rst_mid_over", {153'd0, MEM_over}, 154'd0);
      MEM_valid = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      run_op("post_rst_lbu", 4'd5, 32'h106, 32'd0, 1'b1, 5'd15, 32'hBFC0_0048);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 154'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
